// File: rtl/arbiter_mux.sv
// arbiter_mux: packet-aware N:1 stream multiplexer placed behind a registered
// arbiter. Drives the arbiter's request vector from the input valids, locks onto
// a one-hot grant and forwards that port's beats into a registered output stage.
// Port i is bit i of every [0:NUM_PORTS-1] vector (port 0 is the MSB).
//
// Build option: define ARBITER_MUX_PACKET_EN to hold a grant until the s_last
// beat. Without it every transferred beat ends its grant (one beat per grant).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a one-hot grant; no port is accepted
// LOCK    | port sel is forwarded; s_ready[sel] follows the output stage
// RELEASE | request[sel] masked; waiting for the arbiter to drop grant[sel]
module arbiter_mux #(
  parameter int NUM_PORTS  = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [0:NUM_PORTS-1]            s_valid,
  input  logic [0:NUM_PORTS-1]            s_last,
  output logic [0:NUM_PORTS-1]            s_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_valid,
  output logic                            m_last,
  input  logic                            m_ready,
  output logic [0:NUM_PORTS-1]            request,
  input  logic [0:NUM_PORTS-1]            grant,
  input  logic                            active
);

  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(NUM_PORTS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                  state;
  logic [SEL_W-1:0]        sel;

  logic [CNT_W-1:0]        grant_cnt;
  logic [SEL_W-1:0]        grant_idx;
  logic                    grant_onehot;

  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_valid;
  logic                    sel_last;
  logic                    sel_grant;

  logic                    out_free;
  logic                    xfer;
  logic                    end_of_grant;

  // Count grant bits and remember the index of the set one; only a single set
  // bit is accepted as a usable grant.
  always_comb begin
    grant_cnt = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        grant_cnt = grant_cnt + CNT_W'(1);
        grant_idx = SEL_W'(i);
      end
    end
    grant_onehot = (grant_cnt == CNT_W'(1));
  end

  // Select the locked port's beat, valid, last and grant bit.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_grant = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
        sel_grant = grant[i];
      end
    end
  end

  // The output stage can take a beat when empty or draining this cycle.
  assign out_free = !m_valid || m_ready;
  assign xfer     = (state == LOCK) && !rst && sel_valid && out_free;

`ifdef ARBITER_MUX_PACKET_EN
  assign end_of_grant = sel_last;
`else
  assign end_of_grant = 1'b1;
`endif

  // Per-port accept and arbiter request; both are silenced while in reset so
  // nothing is handshaken during a reset cycle.
  always_comb begin
    s_ready = '0;
    request = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!rst && (state == LOCK) && (sel == SEL_W'(i))) begin
        s_ready[i] = out_free;
      end
      if (!rst && !((state == RELEASE) && (sel == SEL_W'(i)))) begin
        request[i] = s_valid[i];
      end
    end
  end

  // FSM and registered output stage; a load takes priority over a drain so a
  // simultaneous drain+load sustains one beat per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      if (xfer) begin
        m_data  <= sel_data;
        m_last  <= sel_last;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (active && grant_onehot) begin
            sel   <= grant_idx;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (xfer && end_of_grant) begin
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!sel_grant) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_mux.sv
// Testbench for arbiter_mux: includes a round-robin arbiter model, per-port
// stream sources and a transfer-order scoreboard for the output stream.
module tb_arbiter_mux;

  localparam int NP = 9;
  localparam int DW = 8;

`ifdef ARBITER_MUX_PACKET_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*DW-1:0]  s_data;
  logic [0:NP-1]     s_valid, s_last, s_ready;
  logic [DW-1:0]     m_data;
  logic              m_valid, m_last, m_ready;
  logic [0:NP-1]     request, grant;
  logic              active;

  always #5 clk = ~clk;

  arbiter_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .request(request), .grant(grant), .active(active)
  );

  // ---------------- arbiter model: registered round-robin, holds while the
  // granted port keeps requesting
  logic [0:NP-1] grant_arb, grant_force;
  logic          use_arb, active_force;
  int            last_g, pick;

  always @(posedge clk) begin
    if (rst) begin
      grant_arb <= '0;
      last_g    <= NP - 1;
    end else if ((grant_arb & request) != '0) begin
      grant_arb <= grant_arb;
    end else begin
      pick = -1;
      for (int k = 1; k <= NP; k++)
        if (pick < 0 && request[(last_g + k) % NP]) pick = (last_g + k) % NP;
      grant_arb <= '0;
      if (pick >= 0) begin
        grant_arb[pick] <= 1'b1;
        last_g          <= pick;
      end
    end
  end

  assign grant  = use_arb ? grant_arb : grant_force;
  assign active = use_arb ? (grant_arb != '0) : active_force;

  // ---------------- bench state
  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [3:0] port; logic [DW-1:0] data; logic last; } exp_t;

  beat_t         tx_q[NP][$];
  exp_t          exp_q[$];
  int            unit_port[$];
  int            seq[NP];
  bit            seen_port[NP];
  logic [0:NP-1] presenting;
  int            gap_pct, mready_mode;
  int            passed, total;
  int            cur_pkt_port;
  bit            rel_pending;
  int            rel_port;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit all_tx_empty();
    for (int p = 0; p < NP; p++) if (tx_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_beat(input int p, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    tx_q[p].push_back(b);
  endtask

  task automatic send_pkt(input int p, input int len);
    for (int j = 0; j < len; j++) begin
      push_beat(p, {4'(p), 4'(seq[p])}, (j == len - 1));
      seq[p]++;
    end
  endtask

  task automatic clear_tb();
    for (int p = 0; p < NP; p++) tx_q[p].delete();
    exp_q.delete();
    presenting   = '0;
    s_valid      = '0;
    s_last       = '0;
    cur_pkt_port = -1;
    rel_pending  = 1'b0;
  endtask

  // One clock: sample handshakes at the falling edge, update models after the
  // rising edge, then drive the next source/sink values.
  task automatic tick();
    logic [0:NP-1]  fire;
    logic           mfire, ml;
    logic [DW-1:0]  md;
    int             fp;
    beat_t          b;
    exp_t           e;
    @(negedge clk);
    if (rel_pending) begin
      chk("release_sready_zero", s_ready, 0);
      chk("release_request_masked", request[rel_port], 0);
      rel_pending = 1'b0;
    end
    fire  = s_valid & s_ready;
    mfire = m_valid & m_ready;
    md    = m_data;
    ml    = m_last;
    chk("at_most_one_fire", ($countones(fire) <= 1), 1);
    fp = -1;
    for (int p = 0; p < NP; p++) if (fire[p]) fp = p;
    @(posedge clk);
    #1;
    if (mfire) begin
      chk("out_beat_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", md, e.data);
        chk("out_last", ml, e.last);
        seen_port[e.port] = 1'b1;
`ifdef ARBITER_MUX_PACKET_EN
        if (cur_pkt_port >= 0) chk("no_interleave", e.port, cur_pkt_port);
        cur_pkt_port = e.last ? -1 : int'(e.port);
`endif
        if (e.last || !PKT) unit_port.push_back(int'(e.port));
      end
    end
    if (fp >= 0) begin
      b = tx_q[fp].pop_front();
      e.port = 4'(fp);
      e.data = b.data;
      e.last = b.last;
      exp_q.push_back(e);
      presenting[fp] = 1'b0;
      rel_pending    = b.last || !PKT;
      rel_port       = fp;
    end
    for (int p = 0; p < NP; p++) begin
      if (!presenting[p] && tx_q[p].size() > 0 && $urandom_range(99) >= gap_pct)
        presenting[p] = 1'b1;
      if (presenting[p]) begin
        s_data[p*DW +: DW] = tx_q[p][0].data;
        s_last[p]          = tx_q[p][0].last;
      end else begin
        s_data[p*DW +: DW] = '0;
        s_last[p]          = 1'b0;
      end
    end
    s_valid = presenting;
    case (mready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(1));
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    clear_tb();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    bit idle;
    gap_pct     = 0;
    mready_mode = 0;
    n    = 0;
    idle = 1'b0;
    while (!idle && n < budget) begin
      tick();
      n++;
      idle = (exp_q.size() == 0) && !m_valid && (presenting == '0) && all_tx_empty();
    end
    chk(name, idle, 1);
  endtask

  // ---------------- vector table for grant decoding and request gating
  typedef struct {
    logic          r;
    logic [0:NP-1] sv;
    logic [0:NP-1] g;
    logic          act;
    logic [0:NP-1] exp_req;
    logic [0:NP-1] exp_rdy;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int arr[$];
    int period, n;
    bit found;

    rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b1;
    use_arb = 1'b0; grant_force = '0; active_force = 1'b0;
    presenting = '0; gap_pct = 0; mready_mode = 0;
    passed = 0; total = 0; cur_pkt_port = -1; rel_pending = 1'b0; rel_port = 0;
    for (int p = 0; p < NP; p++) begin seq[p] = 0; seen_port[p] = 1'b0; end

    //            rst   s_valid       grant         act   exp_request   exp_s_ready
    vecs[0] = '{1'b0, 9'b111111111, 9'b000000000, 1'b0, 9'b111111111, 9'b000000000};
    vecs[1] = '{1'b0, 9'b000000000, 9'b100000000, 1'b1, 9'b000000000, 9'b100000000};
    vecs[2] = '{1'b0, 9'b000000001, 9'b000000001, 1'b1, 9'b000000001, 9'b000000001};
    vecs[3] = '{1'b0, 9'b000000000, 9'b000010000, 1'b0, 9'b000000000, 9'b000000000};
    vecs[4] = '{1'b0, 9'b000000000, 9'b110000000, 1'b1, 9'b000000000, 9'b000000000};
    vecs[5] = '{1'b0, 9'b011110000, 9'b000000000, 1'b1, 9'b011110000, 9'b000000000};
    vecs[6] = '{1'b0, 9'b000000000, 9'b000000111, 1'b1, 9'b000000000, 9'b000000000};
    vecs[7] = '{1'b1, 9'b111111111, 9'b001000000, 1'b1, 9'b000000000, 9'b000000000};
    vecs[8] = '{1'b0, 9'b101010101, 9'b000100000, 1'b1, 9'b101010101, 9'b000100000};

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      rst = 1'b1; s_valid = '0; grant_force = '0; active_force = 1'b0;
      @(posedge clk); #1;
      rst = vecs[i].r; s_valid = vecs[i].sv;
      grant_force = vecs[i].g; active_force = vecs[i].act;
      #1;
      chk($sformatf("vec%0d_request", i), request, vecs[i].exp_req);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].exp_rdy);
    end

    // hand over to the arbiter model
    use_arb = 1'b1; grant_force = '0; active_force = 1'b0; s_valid = '0;
    do_reset(2);

    // reset held with ports 0 and 8 valid
    rst = 1'b1;
    push_beat(0, 8'h01, 1'b1);
    push_beat(8, 8'h81, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_quiet", {request, s_ready, m_valid}, 0);
    end
    rst = 1'b0;
    #1;
    chk("request_after_rst", request, 9'b100000001);
    drain("rst_drain", 200);

    // single packet from port 8, followed by a second packet to keep s_valid up
    unit_port.delete();
    push_beat(8, 8'h11, 1'b0);
    push_beat(8, 8'h12, 1'b0);
    push_beat(8, 8'h13, 1'b1);
    push_beat(8, 8'h14, 1'b1);
    tick();
    period = PKT ? 1 : 5;
    arr.delete();
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (m_valid) arr.push_back(k);
    end
    chk("sp_arrivals", (arr.size() >= 3), 1);
    for (int j = 0; j < 3 && j < arr.size(); j++)
      chk($sformatf("sp_beat%0d_cycle", j), arr[j], 3 + j * period);
    drain("sp_drain", 200);

    // contention: ports 0 and 8, four 2-beat packets each
    unit_port.delete();
    for (int i = 0; i < 4; i++) begin
      push_beat(0, 8'hA0, 1'b0); push_beat(0, 8'hA1, 1'b1);
      push_beat(8, 8'hB0, 1'b0); push_beat(8, 8'hB1, 1'b1);
    end
    drain("cont_drain", 500);
    chk("cont_units", unit_port.size(), PKT ? 8 : 16);
    for (int i = 1; i < unit_port.size(); i++)
      chk("cont_alternate", (unit_port[i] != unit_port[i-1]), 1);

    // backpressure on beat 2 of a 4-beat packet
    for (int j = 1; j <= 4; j++) push_beat(3, 8'(8'h30 + j), (j == 4));
    found = 1'b0;
    n = 0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (m_valid && m_data == 8'h32) found = 1'b1;
    end
    chk("bp_beat2_seen", found, 1);
    mready_mode = 2;
    m_ready     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", {m_valid, m_data}, {1'b1, 8'h32});
      chk("bp_s_ready_zero", s_ready, 0);
    end
    mready_mode = 0;
    m_ready     = 1'b1;
    drain("bp_drain", 200);

    // reset pulse after beat 2 of a 4-beat packet
    for (int j = 1; j <= 4; j++) push_beat(5, 8'(8'h50 + j), (j == 4));
    found = 1'b0;
    n = 0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (m_valid && m_data == 8'h52) found = 1'b1;
    end
    chk("mid_rst_beat2_seen", found, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_m_valid", m_valid, 0);
    clear_tb();
    rst = 1'b0;
    #1;
    chk("mid_rst_idle_s_ready", s_ready, 0);
    send_pkt(1, 3);
    send_pkt(6, 1);
    drain("post_rst_drain", 300);

    // all ports valid for 60 cycles: every port must reach the output
    for (int p = 0; p < NP; p++) begin
      seen_port[p] = 1'b0;
      for (int j = 0; j < 4; j++) push_beat(p, {4'(p), 4'(j)}, 1'b1);
    end
    repeat (60) tick();
    for (int p = 0; p < NP; p++) chk($sformatf("all_valid_port%0d_seen", p), seen_port[p], 1);
    drain("all_valid_drain", 2000);

    // randomized traffic with random gaps and output backpressure
    gap_pct     = 30;
    mready_mode = 1;
    for (int c = 0; c < 1200; c++) begin
      for (int p = 0; p < NP; p++)
        if (tx_q[p].size() < 3 && $urandom_range(99) < 10) send_pkt(p, 1 + $urandom_range(3));
      tick();
    end
    drain("rand_drain", 3000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
